// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
// Holds the FSM encoding and the round-robin pick helper.
package counter_arb_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned NREQ          = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // With both requesting, the one not served last wins; otherwise the lone requester wins.
  function automatic logic rr_pick(input logic [NREQ-1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Request/grant bus between the requesters and the counter arbiter.
interface counter_arbiter_if
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [NREQ-1:0]  done;
  logic [WIDTH-1:0] counter_out;

  modport master (
    output req, len0, len1,
    input  grant, busy, done, counter_out
  );

  modport slave (
    input  req, len0, len1,
    output grant, busy, done, counter_out
  );

endinterface

// File: rtl/tick_counter.sv
// Shared tick counter; clear takes priority over enable.
module tick_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter lending one tick counter to two requesters for a latched number of cycles.
// Owner finishes with a one-cycle done pulse, or aborts early by dropping its request.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  counter_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [WIDTH-1:0]  len_q, len_d;

  logic              cnt_clear;
  logic              cnt_enable;
  logic [WIDTH-1:0]  count;
  logic              winner;
  logic [WIDTH-1:0]  last_tick;
  logic              terminal;
  logic              abort;

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

  assign winner    = rr_pick(bus.req, last_q);
  // A latched length of zero wraps to all-ones, giving the full 2^WIDTH ticks.
  assign last_tick = len_q - WIDTH'(1);
  assign terminal  = (count == last_tick);
  assign abort     = ~bus.req[owner_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    owner_d    = owner_q;
    last_d     = last_q;
    len_d      = len_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_clear = 1'b1;
        if (|bus.req) begin
          state_d = StRun;
          owner_d = winner;
          grant_d = idx_to_onehot(winner);
          len_d   = winner ? bus.len1 : bus.len0;
        end
      end

      StRun: begin
        // Abort outranks terminal count: no done pulse when both happen together.
        if (abort) begin
          state_d   = StIdle;
          grant_d   = '0;
          last_d    = owner_q;
          cnt_clear = 1'b1;
        end else if (terminal) begin
          state_d = StDone;
          grant_d = '0;
          done_d  = idx_to_onehot(owner_q);
          last_d  = owner_q;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      StDone: begin
        state_d   = StIdle;
        cnt_clear = 1'b1;
      end

      default: begin
        state_d   = StIdle;
        grant_d   = '0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= len_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q == StRun) || (state_q == StDone);
  assign bus.counter_out = count;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_counter_arbiter;

  localparam int unsigned W      = 4;
  localparam int          FULL_L = 1 << W;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  counter_arbiter_if #(.WIDTH(W)) bus ();

  counter_arbiter #(
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 running, 2 reporting done.
  int m_phase, m_owner, m_cnt, m_len, m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_cnt   = 0;
    m_len   = 0;
    m_last  = 1;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        if (bus.req != 2'b00) begin
          if (bus.req == 2'b11) m_owner = 1 - m_last;
          else                  m_owner = bus.req[1] ? 1 : 0;
          m_len = (m_owner == 1) ? int'(bus.len1) : int'(bus.len0);
          if (m_len == 0) m_len = FULL_L;
          m_cnt   = 0;
          m_phase = 1;
        end
      end
      1: begin
        if (!bus.req[m_owner]) begin
          m_phase = 0;
          m_cnt   = 0;
          m_last  = m_owner;
        end else if (m_cnt == m_len - 1) begin
          m_phase = 2;
          m_last  = m_owner;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        m_phase = 0;
        m_cnt   = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [1:0] oh;
    oh = (m_owner == 1) ? 2'b10 : 2'b01;
    check_eq("grant", bus.grant, (m_phase == 1) ? oh : 2'b00);
    check_eq("busy", bus.busy, (m_phase != 0) ? 1'b1 : 1'b0);
    check_eq("done", bus.done, (m_phase == 2) ? oh : 2'b00);
    check_eq("counter_out", bus.counter_out, m_cnt);
    check_eq("grant_onehot0", $onehot0(bus.grant), 1'b1);
  endtask

  // One clock: predict, let the edge happen, compare; owner releases after its done pulse.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_outputs();
    if (m_phase == 2) bus.req[m_owner] = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 2'b00;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bus.req = 2'b00;
    for (int i = 0; i < 4 && m_phase != 0; i++) step();
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    do_reset();

    // Single request, length 3; later len changes must not matter.
    bus.len0 = 4'd3;
    bus.req  = 2'b01;
    step();
    check_eq("single_grant", bus.grant, 2'b01);
    bus.len0 = 4'd15;
    for (int i = 0; i < 5; i++) step();
    check_eq("single_idle_cnt", bus.counter_out, 0);

    // Contention right after reset: requester 0 first.
    do_reset();
    bus.len0 = 4'd2;
    bus.len1 = 4'd4;
    bus.req  = 2'b11;
    step();
    check_eq("contend_first", bus.grant, 2'b01);
    for (int i = 0; i < 12 && !(m_phase == 1 && m_owner == 1); i++) step();
    check_eq("contend_second", bus.grant, 2'b10);
    for (int i = 0; i < 8; i++) step();

    // Zero length means the full 16-tick run.
    drain();
    bus.len1 = 4'd0;
    bus.req  = 2'b10;
    for (int i = 0; i < 16; i++) step();
    check_eq("zero_len_top", bus.counter_out, 15);
    step();
    check_eq("zero_len_done", bus.done, 2'b10);
    step();

    // Abort at count 4, then the contested grant goes to requester 1.
    drain();
    bus.len0 = 4'd8;
    bus.req  = 2'b01;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_cnt == 4); i++) step();
    check_eq("abort_at4", bus.counter_out, 4);
    bus.req[0] = 1'b0;
    step();
    check_eq("abort_no_done", bus.done, 2'b00);
    bus.len1 = 4'd2;
    bus.req  = 2'b11;
    step();
    check_eq("abort_rr", bus.grant, 2'b10);
    for (int i = 0; i < 4; i++) step();

    // Abort coinciding with terminal count.
    drain();
    bus.len0 = 4'd2;
    bus.req  = 2'b01;
    step();
    step();
    check_eq("tc_abort_cnt", bus.counter_out, 1);
    bus.req[0] = 1'b0;
    step();
    check_eq("tc_abort_done", bus.done, 2'b00);
    check_eq("tc_abort_busy", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a run.
    bus.len0 = 4'd8;
    bus.req  = 2'b01;
    for (int i = 0; i < 20 && !(m_phase == 1 && m_cnt == 5); i++) step();
    check_eq("pre_reset_cnt", bus.counter_out, 5);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_grant", bus.grant, 2'b00);
    check_eq("async_busy", bus.busy, 1'b0);
    check_eq("async_cnt", bus.counter_out, 0);
    do_reset();
    bus.req = 2'b11;
    step();
    check_eq("post_reset_grant", bus.grant, 2'b01);

    // Random traffic: requests held until done or a random abort by the owner.
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!bus.req[r]) begin
          if ($urandom_range(2) == 0) bus.req[r] = 1'b1;
        end else if (m_phase == 1 && m_owner == r && $urandom_range(23) == 0) begin
          bus.req[r] = 1'b0;
        end
      end
      if ($urandom_range(3) == 0) bus.len0 = W'($urandom);
      if ($urandom_range(3) == 0) bus.len1 = W'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
